alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station that sits between rename/dispatch and the ALU and drives the ALU's operand interface (op code, two operands).
- Buffers decoded ALU ops that are waiting on physical-register operands.
- Captures operand values from the common data bus (CDB).
- Issues at most one ready op per cycle, as registered ALU inputs plus a destination tag for writeback.

Parameters:
- WORD_SIZE, 32, operand/result width
- NUM_P_REGS, 64, physical registers; TAG_W = $clog2(NUM_P_REGS)
- ALU_OP_SIZE, 4, ALU op code width
- NUM_ENTRIES, 4, station depth (power of 2, >=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all entries (mispredict)
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  station can accept a dispatch
- disp_op_i  in  ALU_OP_SIZE  ALU op code
- disp_src0_tag_i  in  TAG_W  source 0 physical tag
- disp_src0_rdy_i  in  1  source 0 value already valid
- disp_src0_val_i  in  WORD_SIZE  source 0 value (if ready)
- disp_src1_tag_i / disp_src1_rdy_i / disp_src1_val_i  in  TAG_W/1/WORD_SIZE  same, source 1
- disp_dest_tag_i  in  TAG_W  destination physical tag
- cdb_valid_i  in  1  result broadcast
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_data_i  in  WORD_SIZE  broadcast value
- issue_valid_o  out  1  ALU inputs valid this cycle
- alu_op_o  out  ALU_OP_SIZE  to ALU op input
- alu_data0_o  out  WORD_SIZE  to ALU operand 0
- alu_data1_o  out  WORD_SIZE  to ALU operand 1
- issue_dest_o  out  TAG_W  destination tag accompanying the issue
- occupancy_o  out  $clog2(NUM_ENTRIES)+1  valid entry count

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all entry valid bits 0; issue_valid_o=0; alu_op_o=0; alu_data0_o=0; alu_data1_o=0; issue_dest_o=0; occupancy_o=0; disp_ready_o=1 in the cycle after reset.
- Entry contents: valid, op, per-source {tag, rdy, val}, dest.
- Dispatch:
  - Accepted when disp_valid_i && disp_ready_o. Written into the lowest-index free entry.
  - disp_ready_o = (occupancy_o != NUM_ENTRIES). It is based on the registered count only; a slot freed by an issue in the same cycle is not reusable until the next cycle.
- Wakeup: on cdb_valid_i, every valid entry with a not-ready source whose tag equals cdb_tag_i sets rdy=1 and val=cdb_data_i.
  - Also applies to the entry being dispatched in the same cycle: a not-ready dispatch source matching the CDB is written ready with cdb_data_i.
  - A single broadcast may wake both sources of one entry.
- Select: an entry is eligible when valid and both rdy bits are 1, using registered state only. Consequences:
  - An entry woken or dispatched in cycle N is first eligible in cycle N+1.
  - Minimum dispatch-to-issue_valid_o latency is 2 cycles.
  - The default priority is lowest index.
- Issue:
  - Issue is registered. The next-cycle issue_valid_o=1 and alu_op_o / alu_data0_o / alu_data1_o / issue_dest_o are loaded from the selected entry, and that entry's valid bit is cleared.
  - With no eligible entry, issue_valid_o=0 and the data outputs hold their previous values.
  - The ALU is always accepting; there is no issue backpressure.
- Occupancy: occupancy_o increments on accept, decrements on issue, and is unchanged when both happen in the same cycle. It never exceeds NUM_ENTRIES and never underflows.
- Flush (priority order rst_i > flush_i > normal operation):
  - Clears all valid bits and occupancy.
  - Forces issue_valid_o=0 next cycle.
  - A dispatch presented in the flush cycle is dropped.
  - CDB activity in the flush cycle is ignored.
- Reset mid-operation: identical to flush, plus all output registers return to their reset values.

Optional Feature:
- Macro: ALU_RS_OLDEST_FIRST_EN.
- Defined:
  - Each entry stores a dispatch sequence stamp of width $clog2(NUM_ENTRIES)+1 from a wrapping counter.
  - Select picks the eligible entry with the oldest stamp, compared wrap-aware as a modular difference from the counter.
  - The counter resets to 0 on rst_i/flush_i.
- Undefined: fixed lowest-index priority, and no stamp storage is built.
- Port list is identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - The ALU op code constants: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, XOR 4'b1000, SRA 4'b1001.
  - The TAG_W function/localparam.
  - A packed typedef rs_entry_t {valid, op, src0, src1, dest}.
  - A typedef rs_src_t {tag, rdy, val}.
- One sub-module: rs_select. It is a combinational priority picker taking eligible vector (plus stamps under the macro) and returning one-hot grant and found.

Test Plan:
- Ready dispatch: reset, then dispatch ADD src0 rdy 5, src1 rdy 7, dest 12 -> issue_valid_o=1 exactly 2 cycles after accept; alu_op_o=4'b0010, data0=5, data1=7, issue_dest_o=12; occupancy back to 0.
- Waiting source: dispatch SUB with src0 not ready tag 9, src1 rdy 3; CDB tag 9 data 20 three cycles later -> issue the cycle after the broadcast with data0=20, data1=3; no issue before.
- Same-cycle capture: dispatch with src1 tag 4 not ready while cdb_valid_i tag 4 data 0xFFFF_FFF0 -> entry issues 2 cycles after accept with data1=0xFFFF_FFF0.
- Full: fill 4 unready entries -> disp_ready_o=0, occupancy_o=4. A fifth disp_valid_i is not accepted. One wakeup/issue -> disp_ready_o=1 the cycle after the issue.
- Flush: 3 entries valid and 1 issuing, assert flush_i together with a dispatch -> next cycle issue_valid_o=0, occupancy_o=0, dropped dispatch never issues.
- Select order: entries 0 (dispatched second) and 2 (dispatched first) woken together -> lowest-index build issues entry 0 then 2; ALU_RS_OLDEST_FIRST_EN build issues entry 2 then 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, tag width helper and reservation-station entry types.
package alu_pkg;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] XOR = 4'b1000;
    localparam logic [3:0] SRA = 4'b1001;

    localparam int RS_WORD_W = 32;
    localparam int RS_OP_W   = 4;
    localparam int RS_P_REGS = 64;

    function automatic int tag_w(input int n);
        return $clog2(n);
    endfunction

    localparam int TAG_W = tag_w(RS_P_REGS);

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic                 rdy;
        logic [RS_WORD_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic               valid;
        logic [RS_OP_W-1:0] op;
        rs_src_t            src0;
        rs_src_t            src1;
        logic [TAG_W-1:0]   dest;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Combinational issue picker: lowest eligible index, or oldest eligible
// entry when ALU_RS_OLDEST_FIRST_EN is defined.
module rs_select #(
    parameter int N = 4
`ifdef ALU_RS_OLDEST_FIRST_EN
    ,
    parameter int AW = 3
`endif
) (
    input  logic [N-1:0]    elig,
`ifdef ALU_RS_OLDEST_FIRST_EN
    input  logic [N*AW-1:0] age,
`endif
    output logic [N-1:0]    grant,
    output logic            found
);

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [AW-1:0] best;

    // Strict greater-than keeps the lower index on equal age.
    always_comb begin
        grant = '0;
        found = 1'b0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (!found || age[i*AW +: AW] > best)) begin
                grant    = '0;
                grant[i] = 1'b1;
                found    = 1'b1;
                best     = age[i*AW +: AW];
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch buffering, CDB wakeup, registered issue.
// Build option ALU_RS_OLDEST_FIRST_EN selects oldest-first issue order.
module alu_rs #(
    parameter int WORD_SIZE   = 32,
    parameter int NUM_P_REGS  = 64,
    parameter int ALU_OP_SIZE = 4,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          disp_valid_i,
    output logic                          disp_ready_o,
    input  logic [ALU_OP_SIZE-1:0]        disp_op_i,
    input  logic [$clog2(NUM_P_REGS)-1:0] disp_src0_tag_i,
    input  logic                          disp_src0_rdy_i,
    input  logic [WORD_SIZE-1:0]          disp_src0_val_i,
    input  logic [$clog2(NUM_P_REGS)-1:0] disp_src1_tag_i,
    input  logic                          disp_src1_rdy_i,
    input  logic [WORD_SIZE-1:0]          disp_src1_val_i,
    input  logic [$clog2(NUM_P_REGS)-1:0] disp_dest_tag_i,
    input  logic                          cdb_valid_i,
    input  logic [$clog2(NUM_P_REGS)-1:0] cdb_tag_i,
    input  logic [WORD_SIZE-1:0]          cdb_data_i,
    output logic                          issue_valid_o,
    output logic [ALU_OP_SIZE-1:0]        alu_op_o,
    output logic [WORD_SIZE-1:0]          alu_data0_o,
    output logic [WORD_SIZE-1:0]          alu_data1_o,
    output logic [$clog2(NUM_P_REGS)-1:0] issue_dest_o,
    output logic [$clog2(NUM_ENTRIES):0]  occupancy_o
);
    import alu_pkg::*;

    localparam int TW = $clog2(NUM_P_REGS);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int OW = IW + 1;

    rs_entry_t ents [NUM_ENTRIES];
    logic [OW-1:0] occ;

    logic [NUM_ENTRIES-1:0] elig;
    logic [NUM_ENTRIES-1:0] grant;
    logic                   found;
    logic [IW-1:0]          free_idx;
    logic                   accept;
    rs_entry_t              newe;
    rs_src_t                s0_in;
    rs_src_t                s1_in;

    logic [ALU_OP_SIZE-1:0] sel_op;
    logic [WORD_SIZE-1:0]   sel_d0;
    logic [WORD_SIZE-1:0]   sel_d1;
    logic [TW-1:0]          sel_dest;

    assign disp_ready_o = (occ != OW'(NUM_ENTRIES));
    assign accept       = disp_valid_i && disp_ready_o;
    assign occupancy_o  = occ;

    function automatic rs_src_t wake(input rs_src_t s);
        rs_src_t r;
        r = s;
        if (cdb_valid_i && !s.rdy && s.tag == cdb_tag_i) begin
            r.rdy = 1'b1;
            r.val = cdb_data_i;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            elig[i] = ents[i].valid && ents[i].src0.rdy
                      && ents[i].src1.rdy;
        end
    end

    // Scan downward so the lowest free index wins.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ents[i].valid) free_idx = IW'(i);
        end
    end

    assign s0_in = '{tag: disp_src0_tag_i,
                     rdy: disp_src0_rdy_i,
                     val: disp_src0_val_i};
    assign s1_in = '{tag: disp_src1_tag_i,
                     rdy: disp_src1_rdy_i,
                     val: disp_src1_val_i};

    always_comb begin
        newe       = '0;
        newe.valid = 1'b1;
        newe.op    = disp_op_i;
        newe.src0  = wake(s0_in);
        newe.src1  = wake(s1_in);
        newe.dest  = disp_dest_tag_i;
    end

    always_comb begin
        sel_op   = '0;
        sel_d0   = '0;
        sel_d1   = '0;
        sel_dest = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
                sel_op   = ents[i].op;
                sel_d0   = ents[i].src0.val;
                sel_d1   = ents[i].src1.val;
                sel_dest = ents[i].dest;
            end
        end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [OW-1:0]             seq;
    logic [OW-1:0]             stamp [NUM_ENTRIES];
    logic [NUM_ENTRIES*OW-1:0] age;

    // Modular distance from the counter: larger means older.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age[i*OW +: OW] = seq - stamp[i];
        end
    end

    rs_select #(
        .N  (NUM_ENTRIES),
        .AW (OW)
    ) u_select (
        .elig  (elig),
        .age   (age),
        .grant (grant),
        .found (found)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            seq <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) stamp[i] <= '0;
        end else if (accept) begin
            stamp[free_idx] <= seq;
            seq             <= seq + 1'b1;
        end
    end
`else
    rs_select #(
        .N (NUM_ENTRIES)
    ) u_select (
        .elig  (elig),
        .grant (grant),
        .found (found)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ents[i] <= '0;
            occ           <= '0;
            issue_valid_o <= 1'b0;
            alu_op_o      <= '0;
            alu_data0_o   <= '0;
            alu_data1_o   <= '0;
            issue_dest_o  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ents[i].valid <= 1'b0;
            occ           <= '0;
            issue_valid_o <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (ents[i].valid) begin
                    ents[i].src0 <= wake(ents[i].src0);
                    ents[i].src1 <= wake(ents[i].src1);
                end
                if (grant[i]) ents[i].valid <= 1'b0;
            end
            if (accept) ents[free_idx] <= newe;
            issue_valid_o <= found;
            if (found) begin
                alu_op_o     <= sel_op;
                alu_data0_o  <= sel_d0;
                alu_data1_o  <= sel_d1;
                issue_dest_o <= sel_dest;
            end
            occ <= occ + OW'(accept) - OW'(found);
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed scenarios plus random traffic
// against a slot-level behavioural model.
module tb_alu_rs;
    import alu_pkg::*;

    localparam int NE = 4;

    logic        clk = 1'b0;
    logic        rst_i, flush_i;
    logic        disp_valid_i, disp_ready_o;
    logic [3:0]  disp_op_i;
    logic [5:0]  disp_src0_tag_i, disp_src1_tag_i, disp_dest_tag_i;
    logic        disp_src0_rdy_i, disp_src1_rdy_i;
    logic [31:0] disp_src0_val_i, disp_src1_val_i;
    logic        cdb_valid_i;
    logic [5:0]  cdb_tag_i;
    logic [31:0] cdb_data_i;
    logic        issue_valid_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_data0_o, alu_data1_o;
    logic [5:0]  issue_dest_o;
    logic [2:0]  occupancy_o;

    always #5 clk = ~clk;

    alu_rs dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_op_i       (disp_op_i),
        .disp_src0_tag_i (disp_src0_tag_i),
        .disp_src0_rdy_i (disp_src0_rdy_i),
        .disp_src0_val_i (disp_src0_val_i),
        .disp_src1_tag_i (disp_src1_tag_i),
        .disp_src1_rdy_i (disp_src1_rdy_i),
        .disp_src1_val_i (disp_src1_val_i),
        .disp_dest_tag_i (disp_dest_tag_i),
        .cdb_valid_i     (cdb_valid_i),
        .cdb_tag_i       (cdb_tag_i),
        .cdb_data_i      (cdb_data_i),
        .issue_valid_o   (issue_valid_o),
        .alu_op_o        (alu_op_o),
        .alu_data0_o     (alu_data0_o),
        .alu_data1_o     (alu_data1_o),
        .issue_dest_o    (issue_dest_o),
        .occupancy_o     (occupancy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [5:0]  t0, t1, dest;
        bit          r0, r1;
        logic [31:0] v0, v1;
        int          born;
    } slot_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] d0, d1;
        logic [5:0]  dest;
    } iss_t;

    slot_t m [NE];
    int    m_occ = 0;
    int    m_seq = 0;
    iss_t  expq [$];
    bit    exp_valid = 1'b0;
    bit    started = 1'b0;

    // Reference model: advances on every active edge from the sampled inputs.
    always @(posedge clk) begin
        int pick, slot;
        bit acc;
        if (rst_i) begin
            for (int i = 0; i < NE; i++) m[i].v = 1'b0;
            m_occ = 0;
            m_seq = 0;
            exp_valid = 1'b0;
            expq.delete();
            started = 1'b1;
        end else if (flush_i) begin
            for (int i = 0; i < NE; i++) m[i].v = 1'b0;
            m_occ = 0;
            exp_valid = 1'b0;
        end else begin
            pick = -1;
            for (int i = 0; i < NE; i++) begin
                if (m[i].v && m[i].r0 && m[i].r1) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
                    if (pick < 0 || m[i].born < m[pick].born) pick = i;
`else
                    if (pick < 0) pick = i;
`endif
                end
            end
            acc = disp_valid_i && (m_occ < NE);
            slot = -1;
            for (int i = 0; i < NE; i++)
                if (!m[i].v && slot < 0) slot = i;
            if (pick >= 0) begin
                expq.push_back('{op: m[pick].op, d0: m[pick].v0,
                                 d1: m[pick].v1, dest: m[pick].dest});
                m[pick].v = 1'b0;
            end
            exp_valid = (pick >= 0);
            if (cdb_valid_i) begin
                for (int i = 0; i < NE; i++) begin
                    if (m[i].v && !m[i].r0 && m[i].t0 == cdb_tag_i) begin
                        m[i].r0 = 1'b1;
                        m[i].v0 = cdb_data_i;
                    end
                    if (m[i].v && !m[i].r1 && m[i].t1 == cdb_tag_i) begin
                        m[i].r1 = 1'b1;
                        m[i].v1 = cdb_data_i;
                    end
                end
            end
            if (acc) begin
                m[slot] = '{v: 1'b1, op: disp_op_i,
                            t0: disp_src0_tag_i, t1: disp_src1_tag_i,
                            dest: disp_dest_tag_i,
                            r0: disp_src0_rdy_i, r1: disp_src1_rdy_i,
                            v0: disp_src0_val_i, v1: disp_src1_val_i,
                            born: m_seq};
                if (cdb_valid_i && !m[slot].r0
                    && m[slot].t0 == cdb_tag_i) begin
                    m[slot].r0 = 1'b1;
                    m[slot].v0 = cdb_data_i;
                end
                if (cdb_valid_i && !m[slot].r1
                    && m[slot].t1 == cdb_tag_i) begin
                    m[slot].r1 = 1'b1;
                    m[slot].v1 = cdb_data_i;
                end
                m_seq++;
            end
            m_occ = m_occ + (acc ? 1 : 0) - ((pick >= 0) ? 1 : 0);
        end
    end

    // Monitor: compares every cycle, pops an expected issue when one is due.
    always @(negedge clk) begin
        if (started) begin
            chk("occupancy", 32'(occupancy_o), 32'(m_occ));
            chk("disp_ready", 32'(disp_ready_o), 32'(m_occ != NE));
            chk("issue_valid", 32'(issue_valid_o), 32'(exp_valid));
            if (exp_valid && expq.size() > 0) begin
                iss_t e;
                e = expq.pop_front();
                if (issue_valid_o) begin
                    chk("alu_op", 32'(alu_op_o), 32'(e.op));
                    chk("alu_data0", alu_data0_o, e.d0);
                    chk("alu_data1", alu_data1_o, e.d1);
                    chk("issue_dest", 32'(issue_dest_o), 32'(e.dest));
                end
            end
        end
    end

    task automatic quiet();
        disp_valid_i = 1'b0;
        cdb_valid_i  = 1'b0;
        flush_i      = 1'b0;
        rst_i        = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op,
                        input logic [5:0] t0, input bit r0,
                        input logic [31:0] v0,
                        input logic [5:0] t1, input bit r1,
                        input logic [31:0] v1,
                        input logic [5:0] dest);
        disp_valid_i    = 1'b1;
        disp_op_i       = op;
        disp_src0_tag_i = t0;
        disp_src0_rdy_i = r0;
        disp_src0_val_i = v0;
        disp_src1_tag_i = t1;
        disp_src1_rdy_i = r1;
        disp_src1_val_i = v1;
        disp_dest_tag_i = dest;
    endtask

    task automatic bcast(input logic [5:0] t, input logic [31:0] d);
        cdb_valid_i = 1'b1;
        cdb_tag_i   = t;
        cdb_data_i  = d;
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_flush();
        quiet();
        flush_i = 1'b1;
        cyc(1);
        flush_i = 1'b0;
    endtask

    initial begin
        quiet();
        disp(ADD, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        disp_valid_i = 1'b0;
        bcast(0, 0);
        cdb_valid_i = 1'b0;
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        chk("rst_issue_valid", 32'(issue_valid_o), 0);
        chk("rst_alu_op", 32'(alu_op_o), 0);
        chk("rst_data0", alu_data0_o, 0);
        chk("rst_data1", alu_data1_o, 0);
        chk("rst_dest", 32'(issue_dest_o), 0);
        chk("rst_occ", 32'(occupancy_o), 0);
        chk("rst_ready", 32'(disp_ready_o), 1);

        // Ready dispatch: visible two cycles after acceptance.
        disp(ADD, 1, 1'b1, 5, 2, 1'b1, 7, 12);
        cyc(1);
        quiet();
        chk("ready_early", 32'(issue_valid_o), 0);
        cyc(1);
        chk("ready_valid", 32'(issue_valid_o), 1);
        chk("ready_op", 32'(alu_op_o), 32'(ADD));
        chk("ready_d0", alu_data0_o, 5);
        chk("ready_d1", alu_data1_o, 7);
        chk("ready_dest", 32'(issue_dest_o), 12);
        chk("ready_occ", 32'(occupancy_o), 0);
        cyc(2);

        // Waiting source woken three cycles after dispatch.
        disp(SUB, 9, 1'b0, 0, 3, 1'b1, 3, 13);
        cyc(1);
        quiet();
        cyc(2);
        bcast(9, 20);
        cyc(1);
        quiet();
        chk("wait_early", 32'(issue_valid_o), 0);
        cyc(1);
        chk("wait_valid", 32'(issue_valid_o), 1);
        chk("wait_d0", alu_data0_o, 20);
        chk("wait_d1", alu_data1_o, 3);
        cyc(2);

        // Same-cycle capture on dispatch.
        disp(XOR, 5, 1'b1, 32'h11, 4, 1'b0, 0, 14);
        bcast(4, 32'hFFFF_FFF0);
        cyc(1);
        quiet();
        cyc(1);
        chk("cap_valid", 32'(issue_valid_o), 1);
        chk("cap_d1", alu_data1_o, 32'hFFFF_FFF0);
        cyc(2);

        // Full station, rejected fifth dispatch, then one wakeup.
        for (int i = 0; i < NE; i++) begin
            disp(AND, 6'(40 + i), 1'b0, 0, 1, 1'b1, 32'(i), 6'(20 + i));
            cyc(1);
        end
        quiet();
        chk("full_ready", 32'(disp_ready_o), 0);
        chk("full_occ", 32'(occupancy_o), 4);
        disp(SRA, 44, 1'b1, 1, 1, 1'b1, 2, 30);
        cyc(1);
        quiet();
        chk("full_occ_hold", 32'(occupancy_o), 4);
        bcast(41, 32'hABCD);
        cyc(1);
        quiet();
        cyc(1);
        chk("full_iss_dest", 32'(issue_dest_o), 21);
        chk("full_ready_back", 32'(disp_ready_o), 1);
        cyc(1);
        do_flush();

        // Flush with three waiting entries, one issuing, and a dispatch.
        for (int i = 0; i < 3; i++) begin
            disp(ADD, 6'(45 + i), 1'b0, 0, 1, 1'b1, 0, 6'(50 + i));
            cyc(1);
        end
        disp(SUB, 1, 1'b1, 9, 2, 1'b1, 8, 55);
        cyc(1);
        disp(ADD, 1, 1'b1, 1, 2, 1'b1, 1, 60);
        flush_i = 1'b1;
        bcast(45, 1);
        cyc(1);
        quiet();
        chk("flush_valid", 32'(issue_valid_o), 0);
        chk("flush_occ", 32'(occupancy_o), 0);
        cyc(4);

        // Select order: slot 2 older than slot 0, both woken together.
        disp(ADD, 50, 1'b0, 0, 1, 1'b1, 0, 31);
        cyc(1);
        disp(ADD, 51, 1'b0, 0, 1, 1'b1, 0, 32);
        cyc(1);
        disp(ADD, 20, 1'b0, 0, 1, 1'b1, 2, 33);
        cyc(1);
        quiet();
        bcast(50, 7);
        cyc(3);
        disp(SUB, 20, 1'b0, 0, 1, 1'b1, 1, 34);
        cyc(1);
        quiet();
        bcast(20, 99);
        cyc(1);
        quiet();
        cyc(1);
`ifdef ALU_RS_OLDEST_FIRST_EN
        chk("order_first", 32'(issue_dest_o), 33);
`else
        chk("order_first", 32'(issue_dest_o), 34);
`endif
        cyc(1);
`ifdef ALU_RS_OLDEST_FIRST_EN
        chk("order_second", 32'(issue_dest_o), 34);
`else
        chk("order_second", 32'(issue_dest_o), 33);
`endif
        do_flush();
        cyc(1);

        // Random traffic checked by the monitor.
        for (int c = 0; c < 4000; c++) begin
            quiet();
            rst_i   = ($urandom_range(0, 599) == 0);
            flush_i = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 6)
                disp(4'($urandom), 6'($urandom_range(0, 7)),
                     1'($urandom), $urandom,
                     6'($urandom_range(0, 7)), 1'($urandom), $urandom,
                     6'($urandom));
            if ($urandom_range(0, 1) == 1)
                bcast(6'($urandom_range(0, 7)), $urandom);
            cyc(1);
        end
        quiet();
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
